// File: rtl/esc_throttle_ctrl_if.sv
// Command handshake between the flight/host logic and the ESC throttle
// sequencer. The master offers a target throttle; the sequencer accepts
// it while cmd_ready is high.
interface esc_throttle_ctrl_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [7:0] cmd_throttle;

   modport master (output cmd_valid, output cmd_throttle, input cmd_ready);
   modport slave  (input cmd_valid, input cmd_throttle, output cmd_ready);
endinterface

// File: rtl/esc_throttle_ctrl.sv
// ESC arming and throttle sequencer.
// Runs the zero-throttle arming interval, slew-limits throttle changes on
// each control tick and ramps the motor down on disarm or command loss.
// Optional feature macro: ESC_SLEW_EN (defined: slew-limited throttle,
// undefined: throttle jumps straight to target on each tick).
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | driver disabled, waiting for arm_req
// ARMING  | driver enabled at zero throttle for ARM_TICKS ticks
// RUN     | accepting commands, watchdog running
// STOP    | target forced to zero, ramping down to zero throttle
// FAULT   | watchdog expired; driver disabled until fault_clr
module esc_throttle_ctrl #(
   parameter int CLK_DIV   = 50000,
   parameter int ARM_TICKS = 2000,
   parameter int WDT_TICKS = 250,
   parameter int SLEW_STEP = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      arm_req,
   input  logic                      disarm,
   input  logic                      fault_clr,
   esc_throttle_ctrl_if.slave        cmd,
   output logic                      esc_en,
   output logic [7:0]                esc_throttle,
   output logic                      armed,
   output logic                      fault,
   output logic [2:0]                state
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ARMING = 3'd1,
      S_RUN    = 3'd2,
      S_STOP   = 3'd3,
      S_FAULT  = 3'd4
   } state_t;

   localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int AW = $clog2(ARM_TICKS + 1);
   localparam int WW = $clog2(WDT_TICKS + 1);

   localparam logic [TW-1:0] TICK_LAST = TW'(CLK_DIV - 1);
   localparam logic [AW-1:0] ARM_END   = AW'(ARM_TICKS - 1);
   localparam logic [WW-1:0] WDT_END   = WW'(WDT_TICKS - 1);

`ifdef ESC_SLEW_EN
   localparam bit SLEW_ON = 1'b1;
`else
   localparam bit SLEW_ON = 1'b0;
`endif

   // A step of 255 can always reach the target, so the unlimited case
   // shares the same datapath.
   localparam logic [8:0] STEP9 = SLEW_ON ? 9'(SLEW_STEP) : 9'd255;

   state_t          state_q, state_d;
   logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
   logic [AW-1:0]   arm_cnt_q, arm_cnt_d;
   logic [WW-1:0]   wdt_cnt_q, wdt_cnt_d;
   logic [7:0]      target_q, target_d;
   logic            wdt_flag_q, wdt_flag_d;
   logic            esc_en_q, esc_en_d;
   logic [7:0]      esc_throttle_q, esc_throttle_d;
   logic            cmd_ready_q, cmd_ready_d;
   logic            armed_q, armed_d;
   logic            fault_q, fault_d;

   logic            tick;
   logic            accept;
   logic [7:0]      thr_slew;
   logic [8:0]      diff;
   logic [8:0]      mag;

   // Free-running control tick divider.
   always_comb begin
      tick       = (tick_cnt_q == TICK_LAST);
      tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
   end

   // Next throttle one slew step toward the current target (9-bit signed
   // difference, clamps exactly at the target so it never wraps).
   always_comb begin
      diff = {1'b0, target_q} - {1'b0, esc_throttle_q};
      mag  = diff[8] ? (~diff + 9'd1) : diff;
      if (mag <= STEP9) begin
         thr_slew = target_q;
      end else if (diff[8]) begin
         thr_slew = esc_throttle_q - STEP9[7:0];
      end else begin
         thr_slew = esc_throttle_q + STEP9[7:0];
      end
   end

   // Sequencer next-state, counters, target and registered outputs.
   always_comb begin
      state_d        = state_q;
      arm_cnt_d      = arm_cnt_q;
      wdt_cnt_d      = wdt_cnt_q;
      target_d       = target_q;
      wdt_flag_d     = wdt_flag_q;
      esc_throttle_d = esc_throttle_q;
      // disarm outranks a command offered in the same cycle
      accept         = cmd.cmd_valid && cmd_ready_q && !disarm;

      case (state_q)
         S_IDLE: begin
            target_d       = '0;
            wdt_flag_d     = 1'b0;
            arm_cnt_d      = '0;
            wdt_cnt_d      = '0;
            esc_throttle_d = '0;
            if (arm_req) begin
               state_d = S_ARMING;
            end
         end
         S_ARMING: begin
            esc_throttle_d = '0;
            wdt_cnt_d      = '0;
            if (disarm) begin
               state_d = S_IDLE;
            end else if (tick) begin
               arm_cnt_d = arm_cnt_q + 1'b1;
               if (arm_cnt_q == ARM_END) begin
                  state_d = S_RUN;
               end
            end
         end
         S_RUN: begin
            // the tick uses the target held before any same-cycle accept
            if (tick) begin
               esc_throttle_d = thr_slew;
            end
            if (disarm) begin
               state_d    = S_STOP;
               wdt_flag_d = 1'b0;
               target_d   = '0;
            end else if (accept) begin
               target_d  = cmd.cmd_throttle;
               wdt_cnt_d = '0;
            end else if (tick) begin
               wdt_cnt_d = wdt_cnt_q + 1'b1;
               if (wdt_cnt_q == WDT_END) begin
                  state_d    = S_STOP;
                  wdt_flag_d = 1'b1;
                  target_d   = '0;
               end
            end
         end
         S_STOP: begin
            target_d = '0;
            if (esc_throttle_q == 8'd0) begin
               state_d = wdt_flag_q ? S_FAULT : S_IDLE;
            end else if (tick) begin
               esc_throttle_d = thr_slew;
            end
         end
         S_FAULT: begin
            esc_throttle_d = '0;
            if (fault_clr) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d        = S_IDLE;
            esc_throttle_d = '0;
         end
      endcase

      esc_en_d    = (state_d == S_ARMING) || (state_d == S_RUN) || (state_d == S_STOP);
      cmd_ready_d = (state_d == S_RUN);
      armed_d     = (state_d == S_RUN);
      fault_d     = (state_d == S_FAULT);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= S_IDLE;
         tick_cnt_q     <= '0;
         arm_cnt_q      <= '0;
         wdt_cnt_q      <= '0;
         target_q       <= '0;
         wdt_flag_q     <= 1'b0;
         esc_en_q       <= 1'b0;
         esc_throttle_q <= '0;
         cmd_ready_q    <= 1'b0;
         armed_q        <= 1'b0;
         fault_q        <= 1'b0;
      end else begin
         state_q        <= state_d;
         tick_cnt_q     <= tick_cnt_d;
         arm_cnt_q      <= arm_cnt_d;
         wdt_cnt_q      <= wdt_cnt_d;
         target_q       <= target_d;
         wdt_flag_q     <= wdt_flag_d;
         esc_en_q       <= esc_en_d;
         esc_throttle_q <= esc_throttle_d;
         cmd_ready_q    <= cmd_ready_d;
         armed_q        <= armed_d;
         fault_q        <= fault_d;
      end
   end

   assign cmd.cmd_ready = cmd_ready_q;
   assign esc_en        = esc_en_q;
   assign esc_throttle  = esc_throttle_q;
   assign armed         = armed_q;
   assign fault         = fault_q;
   assign state         = state_q;

endmodule

// File: tb/tb_esc_throttle_ctrl.sv
// Bench for esc_throttle_ctrl: behavioural reference model compared every
// cycle, plus directed scenarios with literal expected values.
module tb_esc_throttle_ctrl;

   localparam int CLK_DIV   = 4;
   localparam int ARM_TICKS = 3;
   localparam int WDT_TICKS = 5;
   localparam int SLEW_STEP = 10;
`ifdef ESC_SLEW_EN
   localparam int M_STEP = SLEW_STEP;
`else
   localparam int M_STEP = 255;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       arm_req = 1'b0;
   logic       disarm = 1'b0;
   logic       fault_clr = 1'b0;
   logic       esc_en;
   logic [7:0] esc_throttle;
   logic       armed;
   logic       fault;
   logic [2:0] state;

   esc_throttle_ctrl_if cmd_if ();

   esc_throttle_ctrl #(
      .CLK_DIV   (CLK_DIV),
      .ARM_TICKS (ARM_TICKS),
      .WDT_TICKS (WDT_TICKS),
      .SLEW_STEP (SLEW_STEP)
   ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .arm_req      (arm_req),
      .disarm       (disarm),
      .fault_clr    (fault_clr),
      .cmd          (cmd_if),
      .esc_en       (esc_en),
      .esc_throttle (esc_throttle),
      .armed        (armed),
      .fault        (fault),
      .state        (state)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   bit check_en = 1'b0;

   // reference model state (plain integers)
   int m_state = 0;
   int m_thr = 0;
   int m_target = 0;
   int m_arm = 0;
   int m_wdt = 0;
   int m_flag = 0;
   int m_phase = 0;

   task automatic chk(input string name, input logic [31:0] act, input int exp);
      checks++;
      if (act !== 32'(exp)) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int move_toward(input int cur, input int tgt);
      if (tgt > cur) return (tgt - cur <= M_STEP) ? tgt : cur + M_STEP;
      else           return (cur - tgt <= M_STEP) ? tgt : cur - M_STEP;
   endfunction

   // Reference model, advanced on each rising edge from the sampled inputs.
   always @(posedge clk) begin : model
      bit tk;
      if (rst) begin
         m_state = 0; m_thr = 0; m_target = 0; m_arm = 0;
         m_wdt = 0; m_flag = 0; m_phase = 0;
      end else begin
         tk = (m_phase == CLK_DIV - 1);
         m_phase = (m_phase + 1) % CLK_DIV;
         case (m_state)
            0: if (arm_req) begin m_state = 1; m_arm = 0; end
            1: if (disarm) m_state = 0;
               else if (tk) begin
                  m_arm++;
                  if (m_arm == ARM_TICKS) begin m_state = 2; m_wdt = 0; end
               end
            2: begin
               if (tk) m_thr = move_toward(m_thr, m_target);
               if (disarm) begin m_state = 3; m_flag = 0; m_target = 0; end
               else if (cmd_if.cmd_valid) begin m_target = int'(cmd_if.cmd_throttle); m_wdt = 0; end
               else if (tk) begin
                  m_wdt++;
                  if (m_wdt == WDT_TICKS) begin m_state = 3; m_flag = 1; m_target = 0; end
               end
            end
            3: if (m_thr == 0) m_state = m_flag ? 4 : 0;
               else if (tk) m_thr = move_toward(m_thr, 0);
            4: if (fault_clr) begin m_state = 0; m_flag = 0; end
            default: m_state = 0;
         endcase
      end
   end

   // Cycle-by-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (check_en) begin
         chk("cmp_state", 32'(state), m_state);
         chk("cmp_thr", 32'(esc_throttle), m_thr);
         chk("cmp_en", 32'(esc_en), (m_state >= 1 && m_state <= 3) ? 1 : 0);
         chk("cmp_ready", 32'(cmd_if.cmd_ready), (m_state == 2) ? 1 : 0);
         chk("cmp_armed", 32'(armed), (m_state == 2) ? 1 : 0);
         chk("cmp_fault", 32'(fault), (m_state == 4) ? 1 : 0);
      end
   end

   task automatic wait_state(input string name, input int s, input int budget);
      int n = 0;
      while (state !== 3'(s) && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(name, 32'(state), s);
   endtask

   task automatic next_thr(input int prev, output int val);
      int n = 0;
      while (int'(esc_throttle) == prev && n < 40) begin
         @(negedge clk);
         n++;
      end
      val = int'(esc_throttle);
   endtask

   task automatic ramp(input string name, input int start, input int e[8], input int n);
      int prev = start;
      int v;
      for (int i = 0; i < n; i++) begin
         next_thr(prev, v);
         chk(name, 32'(v), e[i]);
         prev = v;
      end
   endtask

   task automatic pulse_arm();
      @(negedge clk); arm_req = 1'b1;
      @(negedge clk); arm_req = 1'b0;
   endtask

   task automatic send(input int v);
      @(negedge clk); cmd_if.cmd_valid = 1'b1; cmd_if.cmd_throttle = 8'(v);
      @(negedge clk); cmd_if.cmd_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, required finish");
      $fatal(1, "timeout");
   end

   initial begin
      int e[8];
      int n;
      int v;
      cmd_if.cmd_valid = 1'b0;
      cmd_if.cmd_throttle = 8'd0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check_en = 1'b1;
      rst = 1'b0;
      chk("rst_state", 32'(state), 0);
      chk("rst_en", 32'(esc_en), 0);
      chk("rst_thr", 32'(esc_throttle), 0);
      chk("rst_ready", 32'(cmd_if.cmd_ready), 0);

      // arming
      pulse_arm();
      chk("arm_state", 32'(state), 1);
      chk("arm_en", 32'(esc_en), 1);
      chk("arm_thr", 32'(esc_throttle), 0);
      wait_state("arm_done", 2, 20);
      chk("arm_armed", 32'(armed), 1);

      // slew up to 35 then down to 0
      send(35);
`ifdef ESC_SLEW_EN
      e = '{10, 20, 30, 35, 0, 0, 0, 0}; n = 4;
`else
      e = '{35, 0, 0, 0, 0, 0, 0, 0}; n = 1;
`endif
      ramp("up35", 0, e, n);
      send(0);
`ifdef ESC_SLEW_EN
      e = '{25, 15, 5, 0, 0, 0, 0, 0}; n = 4;
`else
      e = '{0, 0, 0, 0, 0, 0, 0, 0}; n = 1;
`endif
      ramp("down35", 35, e, n);

      // command loss: watchdog expiry, ramp-down, fault
      send(35);
`ifdef ESC_SLEW_EN
      e = '{10, 20, 30, 35, 0, 0, 0, 0}; n = 4;
`else
      e = '{35, 0, 0, 0, 0, 0, 0, 0}; n = 1;
`endif
      ramp("up35b", 0, e, n);
      wait_state("wdt_stop", 3, 40);
`ifdef ESC_SLEW_EN
      e = '{25, 15, 5, 0, 0, 0, 0, 0}; n = 4;
`else
      e = '{0, 0, 0, 0, 0, 0, 0, 0}; n = 1;
`endif
      ramp("wdt_ramp", 35, e, n);
      wait_state("wdt_fault", 4, 20);
      chk("fault_flag", 32'(fault), 1);
      chk("fault_en", 32'(esc_en), 0);
      pulse_arm();
      chk("fault_ign_arm", 32'(state), 4);
      @(negedge clk); fault_clr = 1'b1;
      @(negedge clk); fault_clr = 1'b0;
      chk("fault_clr", 32'(state), 0);

      // disarm together with a command: command dropped, ramp to IDLE
      pulse_arm();
      wait_state("arm2", 2, 20);
      send(40);
`ifdef ESC_SLEW_EN
      e = '{10, 20, 30, 40, 0, 0, 0, 0}; n = 4;
`else
      e = '{40, 0, 0, 0, 0, 0, 0, 0}; n = 1;
`endif
      ramp("up40", 0, e, n);
      @(negedge clk);
      disarm = 1'b1; cmd_if.cmd_valid = 1'b1; cmd_if.cmd_throttle = 8'd200;
      @(negedge clk);
      disarm = 1'b0; cmd_if.cmd_valid = 1'b0;
      chk("disarm_stop", 32'(state), 3);
      chk("disarm_ready", 32'(cmd_if.cmd_ready), 0);
`ifdef ESC_SLEW_EN
      e = '{30, 20, 10, 0, 0, 0, 0, 0}; n = 4;
`else
      e = '{0, 0, 0, 0, 0, 0, 0, 0}; n = 1;
`endif
      ramp("disarm_ramp", 40, e, n);
      wait_state("disarm_idle", 0, 20);
      chk("disarm_fault", 32'(fault), 0);

      // accept exactly on the watchdog-expiry tick
      pulse_arm();
      wait_state("arm3", 2, 20);
      n = 0;
      while (!(m_state == 2 && m_wdt == WDT_TICKS - 1 && m_phase == CLK_DIV - 1) && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("wdt_align", 32'(n < 100), 1);
      cmd_if.cmd_valid = 1'b1; cmd_if.cmd_throttle = 8'd50;
      @(negedge clk);
      cmd_if.cmd_valid = 1'b0;
      chk("wdt_keep_run", 32'(state), 2);
      n = 0;
      while (state !== 3'd3 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("wdt_restart", 32'(n), 20);
      wait_state("wdt_fault2", 4, 60);
      @(negedge clk); fault_clr = 1'b1;
      @(negedge clk); fault_clr = 1'b0;

      // reset in RUN at throttle 120
      pulse_arm();
      wait_state("arm4", 2, 20);
      @(negedge clk); cmd_if.cmd_valid = 1'b1; cmd_if.cmd_throttle = 8'd120;
      n = 0;
      while (esc_throttle !== 8'd120 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("reach120", 32'(esc_throttle), 120);
      rst = 1'b1;
      @(negedge clk);
      chk("mrst_state", 32'(state), 0);
      chk("mrst_thr", 32'(esc_throttle), 0);
      chk("mrst_en", 32'(esc_en), 0);
      chk("mrst_ready", 32'(cmd_if.cmd_ready), 0);
      chk("mrst_armed", 32'(armed), 0);
      rst = 1'b0; cmd_if.cmd_valid = 1'b0;

      // first tick after accepting 200
      pulse_arm();
      wait_state("arm5", 2, 20);
      send(200);
      next_thr(0, v);
`ifdef ESC_SLEW_EN
      chk("first200", 32'(v), 10);
`else
      chk("first200", 32'(v), 200);
`endif
      repeat (4) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
